alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 216 +++++++++++++++++++++
 tb/tb_alu_md.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Single-cycle ALU plus iterative shift-add multiplier and restoring divider.
// Multi-cycle ops iterate once per cycle in CALC; every result is presented for one cycle in DONE.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outputport,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     out_q, out_d, hi_q, hi_d;
    logic                 ovf_q, ovf_d;

    logic accept, last, op_multi, op_signed_in;
    logic q_signed, a_neg, b_neg, q_is_div;
    logic [WIDTH-1:0] a_mag_in, b_mag;

    assign accept       = start && (state_q != CALC);
    assign last         = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));
    assign op_multi     = (op >= OP_MULT) && (op <= OP_DIVU);
    assign op_signed_in = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag_in     = (op_signed_in && portA[WIDTH-1]) ? -portA : portA;

    // The iteration works on magnitudes; signs are reapplied when the result is registered.
    assign q_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign q_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign a_neg    = q_signed && a_q[WIDTH-1];
    assign b_neg    = q_signed && b_q[WIDTH-1];
    assign b_mag    = b_neg ? -b_q : b_q;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = op_multi ? CALC : DONE;
                else       state_d = IDLE;
            end
            CALC:    if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    // One multiply or divide step
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     mul_sum, rem_sh, trial;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_mag};
        if (!q_is_div)
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!trial[WIDTH])
            acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Single-cycle result
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_SLL:  alu_res = portA << portB[SW-1:0];
            OP_SRL:  alu_res = portA >> portB[SW-1:0];
            OP_ADD: begin
                alu_res = portA + portB;
                alu_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) && (alu_res[WIDTH-1] != portA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = portA - portB;
                alu_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) && (alu_res[WIDTH-1] != portA[WIDTH-1]);
            end
            OP_AND:  alu_res = portA & portB;
            OP_OR:   alu_res = portA | portB;
            OP_XOR:  alu_res = portA ^ portB;
            OP_NOR:  alu_res = ~(portA | portB);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
            default: alu_res = '0;
        endcase
    end

    // Datapath next-state
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        out_d = out_q;
        hi_d  = hi_q;
        ovf_d = ovf_q;
        prod  = (a_neg ^ b_neg) ? -acc_step : acc_step;
        quo   = (a_neg ^ b_neg) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem   = a_neg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

        if (accept) begin
            op_d  = op;
            a_d   = portA;
            b_d   = portB;
            cnt_d = '0;
            if (op_multi) begin
                acc_d = {{WIDTH{1'b0}}, a_mag_in};
            end else begin
                out_d = alu_res;
                ovf_d = alu_ovf;
            end
        end else if (state_q == CALC) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                if (!q_is_div) begin
                    hi_d  = prod[2*WIDTH-1:WIDTH];
                    out_d = prod[WIDTH-1:0];
                    ovf_d = 1'b0;
                end else if (b_q == '0) begin
                    out_d = '1;
                    hi_d  = a_q;
                    ovf_d = 1'b1;
                end else begin
                    out_d = quo;
                    hi_d  = rem;
                    ovf_d = (op_q == OP_DIV) && (a_q == MIN_NEG) && (b_q == '1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            out_q <= '0;
            hi_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            out_q <= out_d;
            hi_q  <= hi_d;
            ovf_q <= ovf_d;
        end
    end

    assign outputport = out_q;
    assign hi         = hi_q;
    assign overflow   = ovf_q;
    assign zero       = (out_q == '0);
    assign negative   = out_q[WIDTH-1];

endmodule

// File: tb/tb_alu_md.sv
// Directed scenarios plus randomized operations for alu_md (WIDTH=32),
// checked against a plain-arithmetic reference model.
module tb_alu_md;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  portA = '0, portB = '0;
    logic          busy, done, zero, negative, overflow;
    logic [W-1:0]  outputport, hi;

    int checks_total  = 0;
    int checks_passed = 0;

    alu_md #(.WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .portA(portA), .portB(portB),
        .busy(busy), .done(done), .outputport(outputport), .hi(hi),
        .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: results straight from integer arithmetic.
    task automatic model(input logic [3:0] m_op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in,
                         output logic [31:0] o, output logic [31:0] h, output logic v);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o = '0; h = hi_in; v = 1'b0;
        case (m_op)
            4'd0:  o = a << b[4:0];
            4'd1:  o = a >> b[4:0];
            4'd2:  begin r = sa + sb; o = 32'(r); v = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd3:  begin r = sa - sb; o = 32'(r); v = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd4:  o = a & b;
            4'd5:  o = a | b;
            4'd6:  o = a ^ b;
            4'd7:  o = ~(a | b);
            4'd8:  o = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  o = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin p = 64'(sa * sb); h = p[63:32]; o = p[31:0]; end
            4'd11: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; o = p[31:0]; end
            4'd12: begin
                if (b == 32'd0) begin o = '1; h = a; v = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin o = a; h = '0; v = 1'b1; end
                else begin o = 32'(sa / sb); h = 32'(sa % sb); end
            end
            4'd13: begin
                if (b == 32'd0) begin o = '1; h = a; v = 1'b1; end
                else begin o = a / b; h = a % b; end
            end
            default: ;
        endcase
    endtask

    // Issues one op; lat counts rising edges from the accepting edge (inclusive) to done.
    task automatic run_op(input logic [3:0] o_op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output int lat, output int busy_cycles);
        @(negedge CLK);
        start = 1'b1; op = o_op; portA = a; portB = b;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cycles++;
            if (lat == inject_at) begin
                start = 1'b1; op = 4'd2; portA = 32'h1234_5678; portB = 32'h1111_1111;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    logic [31:0] e_out, e_hi, model_hi;
    logic        e_ovf;
    logic        saw_done;
    int          lat, bc;

    initial begin
        model_hi = '0;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", outputport, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        // ADD signed overflow
        run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, -1, lat, bc);
        check("add_lat", 32'(lat), 32'd1);
        check("add_out", outputport, 32'h8000_0000);
        check("add_ovf", 32'(overflow), 32'd1);
        check("add_neg", 32'(negative), 32'd1);
        check("add_zero", 32'(zero), 32'd0);

        // MULTU with an ignored start mid-CALC
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, bc);
        check("multu_lat", 32'(lat), 32'd33);
        check("multu_busy", 32'(bc), 32'd32);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_out", outputport, 32'h0000_0001);
        check("multu_ovf", 32'(overflow), 32'd0);

        // MULT signed, then SLL with shift amount wrapping
        run_op(4'd10, 32'hFFFF_FFFD, 32'd5, -1, lat, bc);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_out", outputport, 32'hFFFF_FFF1);
        run_op(4'd0, 32'd1, 32'd33, -1, lat, bc);
        check("sll_out", outputport, 32'h0000_0002);
        check("sll_hi", hi, 32'hFFFF_FFFF);

        // Signed division truncation, unsigned divide by zero
        run_op(4'd12, 32'hFFFF_FFF9, 32'd2, -1, lat, bc);
        check("div_lat", 32'(lat), 32'd33);
        check("div_out", outputport, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd13, 32'd7, 32'd0, -1, lat, bc);
        check("divu0_out", outputport, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd7);
        check("divu0_ovf", 32'(overflow), 32'd1);

        // Most-negative / -1, then back-to-back SUB from DONE
        run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc);
        check("divmin_out", outputport, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);
        check("divmin_ovf", 32'(overflow), 32'd1);
        run_op(4'd3, 32'd5, 32'd5, -1, lat, bc);
        check("b2b_lat", 32'(lat), 32'd1);
        check("b2b_zero", 32'(zero), 32'd1);
        check("b2b_ovf", 32'(overflow), 32'd0);
        check("b2b_hi", hi, 32'd0);

        // Reset during CALC cycle 10 of DIVU
        @(negedge CLK);
        start = 1'b1; op = 4'd13; portA = 32'd100; portB = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) begin @(posedge CLK); #1; end
        check("abort_busy_before", 32'(busy), 32'd1);
        nRST = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", outputport, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin @(posedge CLK); #1; if (done) saw_done = 1'b1; end
        @(negedge CLK);
        nRST = 1'b1;
        repeat (35) begin @(posedge CLK); #1; if (done) saw_done = 1'b1; end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op(4'd9, 32'd1, 32'd2, -1, lat, bc);
        check("sltu_lat", 32'(lat), 32'd1);
        check("sltu_out", outputport, 32'd1);
        @(posedge CLK); #1;
        check("done_pulse", 32'(done), 32'd0);
        model_hi = '0;

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  r_op;
            logic [31:0] ra, rb;
            r_op = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 40));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            model(r_op, ra, rb, model_hi, e_out, e_hi, e_ovf);
            model_hi = e_hi;
            run_op(r_op, ra, rb, -1, lat, bc);
            check($sformatf("rnd%0d_op%0d_lat", i, r_op), 32'(lat),
                  (r_op >= 4'd10 && r_op <= 4'd13) ? 32'd33 : 32'd1);
            check($sformatf("rnd%0d_op%0d_out", i, r_op), outputport, e_out);
            check($sformatf("rnd%0d_op%0d_hi", i, r_op), hi, e_hi);
            check($sformatf("rnd%0d_op%0d_ovf", i, r_op), 32'(overflow), 32'(e_ovf));
            check($sformatf("rnd%0d_op%0d_zero", i, r_op), 32'(zero), 32'(e_out == 32'd0));
            check($sformatf("rnd%0d_op%0d_neg", i, r_op), 32'(negative), 32'(e_out[31]));
            if ($urandom_range(0, 2) == 0) begin @(posedge CLK); #1; end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
